// File: rtl/cla_multibyte_add_ctrl.sv
// cla_multibyte_add_ctrl
// Adds two NBYTES-wide operands by time-multiplexing an external 8-bit CLA
// adder, one byte per cycle, LSB first. The inter-byte carry is registered,
// so the external adder never forms a combinational loop with this block.
// Handshakes: in_valid/in_ready for operands, out_valid/out_ready for result.
module cla_multibyte_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  zero
);

  localparam int WIDTH = 8 * NBYTES;
  localparam int IDXW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [WIDTH-1:0]  r_op_a;
  logic [WIDTH-1:0]  r_op_b;
  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;
  logic              r_zero;

  logic              w_last;
  logic [WIDTH-1:0]  w_sum_next;
  logic              w_ovf;
  logic              w_zero;

  assign w_last = (r_state == S_RUN) && (r_idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values;
      // a blocking = here would let later statements see the new value.
      r_state <= w_state_next;
    end
  end

  // Next-state logic: accept in IDLE, walk all bytes in RUN, hold in DONE.
  always_comb begin
    // NOTE: assign a default before any branch; a path that leaves a
    // combinational variable unassigned infers a latch.
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid)  w_state_next = S_RUN;
      S_RUN:  if (w_last)    w_state_next = S_DONE;
      S_DONE: if (out_ready) w_state_next = S_IDLE;
      default:               w_state_next = S_IDLE;
    endcase
  end

  // Adder drive: current byte lane and registered carry, zero outside RUN.
  always_comb begin
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
    if (r_state == S_RUN) begin
      add_a   = r_op_a[8*r_idx +: 8];
      add_b   = r_op_b[8*r_idx +: 8];
      add_cin = r_carry;
    end
  end

  // Sum with the byte returned this cycle merged in; on the last byte this is
  // the complete result, so the flags can be registered alongside it.
  always_comb begin
    w_sum_next                = r_sum;
    w_sum_next[8*r_idx +: 8]  = add_sum;
    w_ovf  = (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) &&
             (w_sum_next[WIDTH-1] != r_op_a[WIDTH-1]);
    w_zero = (w_sum_next == '0);
  end

  // Datapath: operand capture on accept, byte-serial accumulate in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: operand and result registers are cleared so a reset mid-run
      // leaves no partial result visible and the adder inputs read zero.
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op_a  <= a;
            r_op_b  <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= add_cout;
          r_idx   <= r_idx + IDXW'(1);
          if (w_last) begin
            r_cout <= add_cout;
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_cla_multibyte_add_ctrl.sv
// tb_cla_multibyte_add_ctrl
// Directed bench for the byte-serial adder controller with a behavioural
// 8-bit adder attached. Expected results are queued at accept time and
// checked by an independent monitor at each output handshake.
module tb_cla_multibyte_add_ctrl;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic [7:0]    add_a;
  logic [7:0]    add_b;
  logic          add_cin;
  logic [7:0]    add_sum;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic          zero;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 8-bit adder seen by the controller (combinational return).
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

  cla_multibyte_add_ctrl #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each result at the output handshake against the queue.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got sum=0x%0h with no result expected", sum);
        end else begin
          e = exp_q.pop_front();
          check("res_sum",  64'(sum),  64'(e.sum));
          check("res_cout", 64'(cout), 64'(e.cout));
          check("res_ovf",  64'(ovf),  64'(e.ovf));
          check("res_zero", 64'(zero), 64'(e.zero));
        end
      end
    end
  end

  // Wait (bounded) until in_ready is seen just after an edge.
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
  endtask

  // Issue one operation and measure edges from accept to out_valid.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                       input res_t e, output int lat, output logic all_cin);
    wait_ready();
    a        = ta;
    b        = tb_v;
    cin      = tc;
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
    lat      = 0;
    all_cin  = 1'b1;
    while (!out_valid && lat < 10) begin
      if (!add_cin) all_cin = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  logic [W-1:0] bb_a [4];
  logic [W-1:0] bb_b [4];
  res_t         bb_e [4];
  int           acc  [4];

  initial begin
    int   lat;
    logic all_cin;
    int   n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_sum",       64'(sum),       64'd0);
    check("rst_flags",     64'({cout, ovf, zero}), 64'd0);
    check("rst_add",       64'({add_a, add_b, add_cin}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Carry out of byte 0 into byte 1.
    issue(32'h000000FF, 32'h00000001, 1'b0, '{32'h00000100, 1'b0, 1'b0, 1'b0}, lat, all_cin);
    check("t1_latency", 64'(lat), 64'd4);
    @(posedge clk);
    #1;
    check("t1_valid_drop", 64'(out_valid), 64'd0);
    check("t1_ready_rise", 64'(in_ready),  64'd1);

    // Full ripple from cin.
    issue(32'hFFFFFFFF, 32'h00000000, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1}, lat, all_cin);
    check("t2_latency", 64'(lat), 64'd4);
    check("t2_cin_all", 64'(all_cin), 64'd1);

    // Signed overflow, positive and negative.
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0}, lat, all_cin);
    check("t3a_latency", 64'(lat), 64'd4);
    issue(32'h80000000, 32'h80000000, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b1}, lat, all_cin);
    check("t3b_latency", 64'(lat), 64'd4);

    // Backpressure with a stray in_valid during DONE.
    wait_ready();
    out_ready = 1'b0;
    issue(32'h01020304, 32'h10203040, 1'b0, '{32'h11223344, 1'b0, 1'b0, 1'b0}, lat, all_cin);
    check("t4_latency", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_valid = 1'b1;
        a        = 32'hAAAAAAAA;
        b        = 32'h55555555;
      end
      if (i == 2) in_valid = 1'b0;
      check("bp_sum",      64'(sum),       64'h11223344);
      check("bp_flags",    64'({cout, ovf, zero}), 64'd0);
      check("bp_valid",    64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready),  64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_drop", 64'(out_valid), 64'd0);
    check("bp_ready_rise", 64'(in_ready),  64'd1);
    check("bp_sum_hold",   64'(sum),       64'h11223344);

    // Reset two RUN cycles into an operation.
    wait_ready();
    a        = 32'hDEADBEEF;
    b        = 32'h01010101;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_add_a_pre", 64'(add_a), 64'hAD);
    rst = 1'b1;
    #1;
    check("mid_out_valid", 64'(out_valid), 64'd0);
    check("mid_in_ready",  64'(in_ready),  64'd1);
    check("mid_add",       64'({add_a, add_b, add_cin}), 64'd0);
    check("mid_sum",       64'(sum),       64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(32'h12345678, 32'h11111111, 1'b0, '{32'h23456789, 1'b0, 1'b0, 1'b0}, lat, all_cin);
    check("t5_latency", 64'(lat), 64'd4);

    // Back-to-back with in_valid and out_ready held high.
    bb_a[0] = 32'h0000FFFF; bb_b[0] = 32'h00000001; bb_e[0] = '{32'h00010000, 1'b0, 1'b0, 1'b0};
    bb_a[1] = 32'h00FF00FF; bb_b[1] = 32'h00010001; bb_e[1] = '{32'h01000100, 1'b0, 1'b0, 1'b0};
    bb_a[2] = 32'h40000000; bb_b[2] = 32'h40000000; bb_e[2] = '{32'h80000000, 1'b0, 1'b1, 1'b0};
    bb_a[3] = 32'hFFFFFFFF; bb_b[3] = 32'h00000001; bb_e[3] = '{32'h00000000, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    wait_ready();
    a        = bb_a[0];
    b        = bb_b[0];
    cin      = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ready();
      @(posedge clk);
      exp_q.push_back(bb_e[k]);
      #1;
      acc[k] = cyc;
      if (k < 3) begin
        a = bb_a[k+1];
        b = bb_b[k+1];
      end else begin
        in_valid = 1'b0;
      end
      if (k > 0) check("bb_spacing", 64'(acc[k] - acc[k-1]), 64'd6);
    end

    // Drain the scoreboard.
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
